// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its sequencer (pipe_ctrl).
// master = datapath side (drives hazard/branch/halt inputs), slave = pipe_ctrl.
interface pipe_ctrl_if;
    logic       enable;
    logic       start;
    logic       jump;
    logic       ex_is_load;
    logic [2:0] ex_dst;
    logic [2:0] id_src1;
    logic [2:0] id_src2;
    logic       id_src1_used;
    logic       id_src2_used;
    logic       wb_halt;

    logic       pc_en;
    logic       pc_load;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       running;
    logic       halted;

    modport master (
        output enable, start, jump, ex_is_load, ex_dst, id_src1, id_src2,
               id_src1_used, id_src2_used, wb_halt,
        input  pc_en, pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, running, halted
    );

    modport slave (
        input  enable, start, jump, ex_is_load, ex_dst, id_src1, id_src2,
               id_src1_used, id_src2_used, wb_halt,
        output pc_en, pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, running, halted
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Run/halt sequencer for the 5-stage pipeline: stage enables, flushes, PC load/hold.
// Optional performance counters (stall_cnt/flush_cnt) when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    pipe_ctrl_if.slave       bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned SC_W = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    if ((STALL_CYCLES < 1) || (STALL_CYCLES > 7)) begin : g_bad_stall_cycles
        $error("pipe_ctrl: STALL_CYCLES must be in 1..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_ctrl: CNT_W must be at least 1");
    end

    logic [1:0]      state_q, state_d;
    logic [SC_W-1:0] cnt_q, cnt_d;
    logic            hazard_c;

    assign hazard_c = bus.ex_is_load &
                      ((bus.id_src1_used & (bus.id_src1 == bus.ex_dst)) |
                       (bus.id_src2_used & (bus.id_src2 == bus.ex_dst)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mealy outputs; priority halt > jump > bubble (stall or fresh hazard)
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bus.pc_en        = 1'b0;
        bus.pc_load      = 1'b0;
        bus.if_id_en     = 1'b0;
        bus.id_ex_en     = 1'b0;
        bus.ex_mem_en    = 1'b0;
        bus.mem_wb_en    = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.running      = (state_q == S_RUN) || (state_q == S_STALL);
        bus.halted       = (state_q == S_HALT);

        if (bus.enable) begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (bus.start) state_d = S_RUN;
                end
                S_RUN, S_STALL: begin
                    if (bus.wb_halt) begin
                        bus.mem_wb_en = 1'b1;
                        state_d       = S_HALT;
                        cnt_d         = '0;
                    end else if (bus.jump) begin
                        bus.pc_en        = 1'b1;
                        bus.pc_load      = 1'b1;
                        bus.if_id_en     = 1'b1;
                        bus.id_ex_en     = 1'b1;
                        bus.ex_mem_en    = 1'b1;
                        bus.mem_wb_en    = 1'b1;
                        bus.if_id_flush  = 1'b1;
                        bus.id_ex_flush  = 1'b1;
                        bus.ex_mem_flush = 1'b1;
                        state_d          = S_RUN;
                        cnt_d            = '0;
                    end else if ((state_q == S_STALL) || hazard_c) begin
                        bus.id_ex_en    = 1'b1;
                        bus.id_ex_flush = 1'b1;
                        bus.ex_mem_en   = 1'b1;
                        bus.mem_wb_en   = 1'b1;
                        if (state_q == S_STALL) begin
                            if (cnt_q <= SC_W'(1)) begin
                                state_d = S_RUN;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q - SC_W'(1);
                            end
                        end else if (STALL_CYCLES > 1) begin
                            state_d = S_STALL;
                            cnt_d   = SC_W'(STALL_CYCLES - 1);
                        end
                    end else begin
                        bus.pc_en     = 1'b1;
                        bus.if_id_en  = 1'b1;
                        bus.id_ex_en  = 1'b1;
                        bus.ex_mem_en = 1'b1;
                        bus.mem_wb_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             go_run_c;

    // A bubble is an id_ex flush without a PC load; outputs are already gated by enable
    always_comb begin
        go_run_c    = bus.enable & bus.start & ((state_q == S_IDLE) || (state_q == S_HALT));
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (go_run_c) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (bus.id_ex_flush && !bus.pc_load && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (bus.pc_load && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (STALL_CYCLES=1 and 3) on shared stimulus,
// compared against a bubble-debt reference model.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable, start, jump, ex_is_load, wb_halt;
    logic       id_src1_used, id_src2_used;
    logic [2:0] ex_dst, id_src1, id_src2;

    always #5 clock = ~clock;

    pipe_ctrl_if bus1 ();
    pipe_ctrl_if bus3 ();

    assign bus1.enable = enable;        assign bus3.enable = enable;
    assign bus1.start = start;          assign bus3.start = start;
    assign bus1.jump = jump;            assign bus3.jump = jump;
    assign bus1.ex_is_load = ex_is_load; assign bus3.ex_is_load = ex_is_load;
    assign bus1.ex_dst = ex_dst;        assign bus3.ex_dst = ex_dst;
    assign bus1.id_src1 = id_src1;      assign bus3.id_src1 = id_src1;
    assign bus1.id_src2 = id_src2;      assign bus3.id_src2 = id_src2;
    assign bus1.id_src1_used = id_src1_used; assign bus3.id_src1_used = id_src1_used;
    assign bus1.id_src2_used = id_src2_used; assign bus3.id_src2_used = id_src2_used;
    assign bus1.wb_halt = wb_halt;      assign bus3.wb_halt = wb_halt;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] sc1, fc1, sc3, fc3;
`endif

    pipe_ctrl #(.STALL_CYCLES(1), .CNT_W(CNT_W)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
    );

    pipe_ctrl #(.STALL_CYCLES(3), .CNT_W(CNT_W)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0=idle 1=active 2=halted; owed = bubbles still owed after the current cycle
    int mode [2];
    int owed [2];
    int scnt [2];
    int fcnt [2];
    int nstall [2] = '{1, 3};

    function automatic bit hazard();
        return ex_is_load && ((id_src1_used && id_src1 == ex_dst) ||
                              (id_src2_used && id_src2 == ex_dst));
    endfunction

    // bit order: pc_en pc_load if_id id_ex ex_mem mem_wb if_fl id_fl ex_fl running halted
    function automatic logic [10:0] got_vec(int k);
        if (k == 0)
            return {bus1.pc_en, bus1.pc_load, bus1.if_id_en, bus1.id_ex_en, bus1.ex_mem_en,
                    bus1.mem_wb_en, bus1.if_id_flush, bus1.id_ex_flush, bus1.ex_mem_flush,
                    bus1.running, bus1.halted};
        return {bus3.pc_en, bus3.pc_load, bus3.if_id_en, bus3.id_ex_en, bus3.ex_mem_en,
                bus3.mem_wb_en, bus3.if_id_flush, bus3.id_ex_flush, bus3.ex_mem_flush,
                bus3.running, bus3.halted};
    endfunction

    function automatic logic [10:0] exp_vec(int k);
        logic [10:0] v;
        v    = '0;
        v[1] = (mode[k] == 1);
        v[0] = (mode[k] == 2);
        if (enable && mode[k] == 1) begin
            if (wb_halt)                       v[10:2] = 9'b000001000;
            else if (jump)                     v[10:2] = 9'b111111111;
            else if (owed[k] > 0 || hazard())  v[10:2] = 9'b000111010;
            else                               v[10:2] = 9'b101111000;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; owed[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!reset || !enable) continue;
            if (mode[k] != 1) begin
                if (start) begin
                    mode[k] = 1; owed[k] = 0; scnt[k] = 0; fcnt[k] = 0;
                end
            end else if (wb_halt) begin
                mode[k] = 2; owed[k] = 0;
            end else if (jump) begin
                owed[k] = 0;
                if (fcnt[k] < CNT_MAX) fcnt[k]++;
            end else if (owed[k] > 0) begin
                owed[k]--;
                if (scnt[k] < CNT_MAX) scnt[k]++;
            end else if (hazard()) begin
                owed[k] = nstall[k] - 1;
                if (scnt[k] < CNT_MAX) scnt[k]++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; start = 1'b0; jump = 1'b0; wb_halt = 1'b0; ex_is_load = 1'b0;
        ex_dst = 3'd0; id_src1 = 3'd1; id_src2 = 3'd2; id_src1_used = 1'b0; id_src2_used = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] g;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            g = got_vec(k);
            checks++;
            if (g !== 11'b0) begin
                errors++; $display("FAIL reset_idle dut%0d: got %b expected %b", k, g, 11'b0);
            end
        end
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            g = got_vec(k);
            checks++;
            if (g !== 11'b10111100010 || g !== exp_vec(k)) begin
                errors++; $display("FAIL start_run dut%0d: got %b expected %b", k, g, 11'b10111100010);
            end
        end
        tick();
        @(negedge clock);
        jump = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            g = got_vec(k);
            checks++;
            if (g !== 11'b0) begin
                errors++; $display("FAIL reset_mid_run dut%0d: got %b expected %b", k, g, 11'b0);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            g = got_vec(k);
            checks++;
            if (g !== 11'b10111100010) begin
                errors++; $display("FAIL restart_run dut%0d: got %b expected %b", k, g, 11'b10111100010);
            end
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [10:0] g;
        idle_inputs();
        ex_is_load = 1'b1; ex_dst = 3'd3; id_src2 = 3'd3; id_src2_used = 1'b1;
        id_src1 = 3'd5; id_src1_used = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                g = got_vec(k);
                checks++;
                if (g !== exp_vec(k)) begin
                    errors++; $display("FAIL load_use dut%0d cyc%0d: got %b expected %b", k, c, g, exp_vec(k));
                end
            end
            if (c == 0) begin
                checks++;
                if (got_vec(0) !== 11'b00011101010) begin
                    errors++; $display("FAIL load_use_bubble dut0: got %b expected %b", got_vec(0), 11'b00011101010);
                end
            end
            tick();
            idle_inputs();
        end
        ex_is_load = 1'b1; ex_dst = 3'd3; id_src2 = 3'd3; id_src2_used = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                g = got_vec(k);
                checks++;
                if (g !== 11'b10111100010 || g !== exp_vec(k)) begin
                    errors++; $display("FAIL src_unused dut%0d cyc%0d: got %b expected %b", k, c, g, 11'b10111100010);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_jump_abort();
        logic [10:0] g;
        idle_inputs();
        ex_is_load = 1'b1; ex_dst = 3'd6; id_src1 = 3'd6; id_src1_used = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                g = got_vec(k);
                checks++;
                if (g !== exp_vec(k)) begin
                    errors++; $display("FAIL jump_abort dut%0d cyc%0d: got %b expected %b", k, c, g, exp_vec(k));
                end
            end
            if (c == 1) begin
                checks++;
                if (got_vec(1) !== 11'b11111111110) begin
                    errors++; $display("FAIL jump_in_stall dut1: got %b expected %b", got_vec(1), 11'b11111111110);
                end
            end
            if (c >= 2) begin
                checks++;
                if (got_vec(1) !== 11'b10111100010) begin
                    errors++; $display("FAIL after_abort dut1 cyc%0d: got %b expected %b", c, got_vec(1), 11'b10111100010);
                end
            end
            tick();
            idle_inputs();
            if (c == 0) jump = 1'b1;
        end
    endtask

    task automatic test_halt_jump();
        logic [10:0] g;
        idle_inputs();
        wb_halt = 1'b1; jump = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                g = got_vec(k);
                checks++;
                if (g !== exp_vec(k)) begin
                    errors++; $display("FAIL halt_jump dut%0d cyc%0d: got %b expected %b", k, c, g, exp_vec(k));
                end
            end
            if (c == 0) begin
                checks++;
                if (got_vec(0) !== 11'b00000100010) begin
                    errors++; $display("FAIL halt_prio dut0: got %b expected %b", got_vec(0), 11'b00000100010);
                end
            end
            if (c == 1) begin
                checks++;
                if (got_vec(1) !== 11'b00000000001) begin
                    errors++; $display("FAIL halted_state dut1: got %b expected %b", got_vec(1), 11'b00000000001);
                end
            end
            tick();
            idle_inputs();
            if (c == 0) wb_halt = 1'b1;
            if (c == 1) start = 1'b1;
        end
        checks++;
        if (bus1.running !== 1'b1 || bus3.running !== 1'b1) begin
            errors++; $display("FAIL restart_after_halt: got %b%b expected 11", bus1.running, bus3.running);
        end
    endtask

    task automatic test_enable_freeze();
        logic [10:0] g;
        idle_inputs();
        ex_is_load = 1'b1; ex_dst = 3'd2; id_src2 = 3'd2; id_src2_used = 1'b1;
        tick();
        idle_inputs();
        enable = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) enable = 1'b1;
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                g = got_vec(k);
                checks++;
                if (g !== exp_vec(k)) begin
                    errors++; $display("FAIL freeze dut%0d cyc%0d: got %b expected %b", k, c, g, exp_vec(k));
                end
            end
            checks++;
            if (c < 4 && got_vec(1) !== 11'b00000000010) begin
                errors++; $display("FAIL freeze_hold dut1 cyc%0d: got %b expected %b", c, got_vec(1), 11'b00000000010);
            end else if ((c == 4 || c == 5) && got_vec(1) !== 11'b00011101010) begin
                errors++; $display("FAIL resume_bubble dut1 cyc%0d: got %b expected %b", c, got_vec(1), 11'b00011101010);
            end else if (c >= 6 && got_vec(1) !== 11'b10111100010) begin
                errors++; $display("FAIL resume_run dut1 cyc%0d: got %b expected %b", c, got_vec(1), 11'b10111100010);
            end
            tick();
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        idle_inputs();
        jump = 1'b1;
        repeat (20) tick();
        idle_inputs();
        @(negedge clock);
        checks++;
        if (fc1 !== 4'd15 || fc3 !== 4'd15) begin
            errors++; $display("FAIL flush_sat: got %0d/%0d expected 15", fc1, fc3);
        end
        wb_halt = 1'b1;
        tick();
        idle_inputs();
        start = 1'b1;
        tick();
        idle_inputs();
        @(negedge clock);
        checks++;
        if (fc1 !== 4'd0 || fc3 !== 4'd0 || sc1 !== 4'd0 || sc3 !== 4'd0) begin
            errors++; $display("FAIL perf_clear: got f%0d/%0d s%0d/%0d expected 0", fc1, fc3, sc1, sc3);
        end
    endtask
`endif

    task automatic test_random();
        logic [10:0] g;
        for (int c = 0; c < 400; c++) begin
            enable       = ($urandom_range(0, 9) != 0);
            start        = ($urandom_range(0, 7) == 0);
            jump         = ($urandom_range(0, 5) == 0);
            wb_halt      = ($urandom_range(0, 24) == 0);
            ex_is_load   = $urandom_range(0, 1) != 0;
            ex_dst       = 3'($urandom_range(0, 3));
            id_src1      = 3'($urandom_range(0, 3));
            id_src2      = 3'($urandom_range(0, 3));
            id_src1_used = $urandom_range(0, 1) != 0;
            id_src2_used = $urandom_range(0, 1) != 0;
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                g = got_vec(k);
                checks++;
                if (g !== exp_vec(k)) begin
                    errors++; $display("FAIL random dut%0d cyc%0d: got %b expected %b", k, c, g, exp_vec(k));
                end
            end
`ifdef PIPE_CTRL_PERF_EN
            checks++;
            if (int'(sc1) != scnt[0] || int'(fc1) != fcnt[0] || int'(sc3) != scnt[1] || int'(fc3) != fcnt[1]) begin
                errors++;
                $display("FAIL random_perf cyc%0d: got s%0d f%0d s%0d f%0d expected s%0d f%0d s%0d f%0d",
                         c, sc1, fc1, sc3, fc3, scnt[0], fcnt[0], scnt[1], fcnt[1]);
            end
`endif
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_jump_abort();
        test_halt_jump();
        test_enable_freeze();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
